// File: rtl/rx_collect_fsm.sv
// Chain receive end: filters words for this port, checks nub sequence,
// rebuilds sop/eop-tagged frames in a local FIFO, drives keep and done.
module rx_collect_fsm #(
  parameter int NUB            = 0,
  parameter int PORT_NUB       = 8,
  parameter int WIDTH_DATA     = 64,
  parameter int WIDTH_LENGTH   = 8,
  parameter int WIDTH_CRC      = 32,
  parameter int WIDTH_PRIORITY = 3,
  parameter int FIFO_DEPTH     = 16,
  localparam int WIDTH_SEL     = $clog2(PORT_NUB),
  localparam int WIDTH_PORT    = WIDTH_SEL + WIDTH_DATA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [WIDTH_SEL-1:0]  nub_in,
  input  logic [WIDTH_PORT-1:0] data_in,
  output logic                  keep_out,
  input  logic [PORT_NUB-1:0]   done_in,
  output logic [PORT_NUB-1:0]   done_out,
  input  logic                  rd_en,
  output logic [WIDTH_DATA-1:0] rd_data,
  output logic                  rd_sop,
  output logic                  rd_eop,
  output logic                  empty,
  output logic                  seq_err,
  output logic                  overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LEN_LO = WIDTH_CRC + WIDTH_PRIORITY;
  localparam int LEN_HI = LEN_LO + WIDTH_LENGTH - 1;
  localparam logic [WIDTH_SEL-1:0] NUB_S  = WIDTH_SEL'(NUB);
  localparam logic [WIDTH_SEL-1:0] NUB_P1 = NUB_S + 1'b1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_KEEP = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [PORT_NUB-1:0] DONE_MASK = PORT_NUB'(1) << NUB;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                  r_state, w_state_nx;
  logic [WIDTH_LENGTH-1:0] r_remain, w_remain_nx;
  logic [WIDTH_SEL-1:0]    r_exp_nub, w_exp_nx;
  logic [CNT_W-1:0]        r_count, w_count_nx;
  logic [PTR_W-1:0]        r_wptr, r_rptr;
  logic [WIDTH_DATA+1:0]   r_mem [FIFO_DEPTH];
  logic                    r_keep, r_seq, r_ovf;
  logic                    r_sop, r_eop;
  logic [WIDTH_DATA-1:0]   r_rdata;
  logic [PORT_NUB-1:0]     r_done;

  logic [WIDTH_SEL-1:0]    w_dest;
  logic [WIDTH_DATA-1:0]   w_payload;
  logic [WIDTH_LENGTH-1:0] w_len;
  logic                    w_hit, w_wr, w_sop, w_eop, w_done, w_seq;
  logic                    w_empty, w_pop, w_push, w_drop;
  logic [PORT_NUB-1:0]     w_done_vec;

  assign w_dest    = data_in[WIDTH_PORT-1 -: WIDTH_SEL];
  assign w_payload = data_in[WIDTH_DATA-1:0];
  assign w_len     = w_payload[LEN_HI:LEN_LO];
  assign w_hit     = valid_in & ~r_keep & (w_dest == NUB_S);

  always_comb begin
    w_state_nx  = r_state;
    w_remain_nx = r_remain;
    w_exp_nx    = r_exp_nub;
    w_wr        = 1'b0;
    w_sop       = 1'b0;
    w_eop       = 1'b0;
    w_done      = 1'b0;
    w_seq       = 1'b0;
    if (w_hit) begin
      unique case (r_state)
        S_IDLE: begin
          if (nub_in == NUB_S) begin
            w_wr  = 1'b1;
            w_sop = 1'b1;
            if (w_len == '0) begin
              w_eop  = 1'b1;
              w_done = 1'b1;
            end else begin
              w_remain_nx = w_len;
              w_exp_nx    = NUB_P1;
              w_state_nx  = S_RUN;
            end
          end else begin
            w_seq = 1'b1;
          end
        end
        S_RUN: begin
          if (nub_in == r_exp_nub) begin
            w_wr        = 1'b1;
            w_exp_nx    = r_exp_nub + 1'b1;
            w_remain_nx = r_remain - 1'b1;
            if (r_remain == WIDTH_LENGTH'(1)) begin
              w_eop      = 1'b1;
              w_done     = 1'b1;
              w_exp_nx   = NUB_S;
              w_state_nx = S_IDLE;
            end
          end else begin
            w_seq = 1'b1;
          end
        end
      endcase
    end
  end

  // a pop in the same cycle frees the slot for a write into a full FIFO
  assign w_empty = (r_count == '0);
  assign w_pop   = rd_en & ~w_empty;
  assign w_push  = w_wr & ((r_count < CNT_FULL) | w_pop);
  assign w_drop  = w_wr & ~w_push;

  always_comb begin
    w_count_nx = r_count;
    if (w_push && !w_pop)
      w_count_nx = r_count + CNT_W'(1);
    else if (!w_push && w_pop)
      w_count_nx = r_count - CNT_W'(1);
  end

  assign w_done_vec = (done_in & ~DONE_MASK) | (w_done ? DONE_MASK : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_remain  <= '0;
      r_exp_nub <= NUB_S;
      r_count   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_keep    <= 1'b0;
      r_seq     <= 1'b0;
      r_ovf     <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_rdata   <= '0;
      r_done    <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_remain  <= w_remain_nx;
      r_exp_nub <= w_exp_nx;
      r_count   <= w_count_nx;
      r_keep    <= (w_count_nx >= CNT_KEEP);
      r_seq     <= w_seq;
      r_done    <= w_done_vec;
      if (w_drop)
        r_ovf <= 1'b1;
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        {r_sop, r_eop, r_rdata} <= r_mem[r_rptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= {w_sop, w_eop, w_payload};
  end

  assign keep_out = r_keep;
  assign done_out = r_done;
  assign rd_data  = r_rdata;
  assign rd_sop   = r_sop;
  assign rd_eop   = r_eop;
  assign empty    = w_empty;
  assign seq_err  = r_seq;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_rx_collect_fsm.sv
// Bench for rx_collect_fsm: directed and random chain streams against
// a frame-level reference model with an entry queue.
module tb_rx_collect_fsm;

  localparam int NUB = 6;
  localparam int PN  = 8;
  localparam int WS  = 3;
  localparam int WD  = 64;
  localparam int WP  = WS + WD;
  localparam int DEPTH = 16;

  logic          clk, rst, valid_in, keep_out, rd_en;
  logic [WS-1:0] nub_in;
  logic [WP-1:0] data_in;
  logic [PN-1:0] done_in, done_out;
  logic [WD-1:0] rd_data;
  logic          rd_sop, rd_eop, empty, seq_err, overflow;

  rx_collect_fsm #(
    .NUB(NUB), .PORT_NUB(PN), .WIDTH_DATA(WD), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .nub_in(nub_in),
    .data_in(data_in), .keep_out(keep_out), .done_in(done_in),
    .done_out(done_out), .rd_en(rd_en), .rd_data(rd_data),
    .rd_sop(rd_sop), .rd_eop(rd_eop), .empty(empty),
    .seq_err(seq_err), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_pass, n_fail;

  logic [WD+1:0] q[$];
  bit            m_inframe, m_keep, m_seq, m_ovf, m_rsop, m_reop;
  bit            keep_forced;
  int            m_remain, m_exp;
  logic [PN-1:0] m_done;
  logic [WD-1:0] m_rdata;
  logic [WS+WP-1:0] sq[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_inframe = 0; m_remain = 0; m_exp = NUB;
    m_keep = 0; m_seq = 0; m_ovf = 0;
    m_done = '0; m_rdata = '0; m_rsop = 0; m_reop = 0;
  endtask

  task automatic model_step(input bit v, input logic [WS-1:0] n,
                            input logic [WP-1:0] d, input bit re,
                            input logic [PN-1:0] di);
    bit pop, can, hit, wr, sop, eop, dn, se;
    int len;
    logic [WD+1:0] e;
    pop = re && q.size() > 0;
    can = q.size() < DEPTH || pop;
    if (pop) begin
      e = q.pop_front();
      m_rsop = e[WD+1]; m_reop = e[WD]; m_rdata = e[WD-1:0];
    end
    hit = v && !m_keep && (int'(d[WP-1:WD]) == NUB);
    wr = 0; sop = 0; eop = 0; dn = 0; se = 0;
    if (hit) begin
      if (!m_inframe) begin
        if (int'(n) == NUB) begin
          wr = 1; sop = 1; len = int'(d[42:35]);
          if (len == 0) begin
            eop = 1; dn = 1;
          end else begin
            m_inframe = 1; m_remain = len; m_exp = (NUB + 1) % PN;
          end
        end else se = 1;
      end else if (int'(n) == m_exp) begin
        wr = 1; m_remain--; m_exp = (m_exp + 1) % PN;
        if (m_remain == 0) begin
          eop = 1; dn = 1; m_inframe = 0;
        end
      end else se = 1;
    end
    if (wr) begin
      if (can) q.push_back({sop, eop, d[WD-1:0]});
      else m_ovf = 1;
    end
    m_seq = se;
    m_keep = keep_forced ? 1'b0 : (q.size() >= DEPTH - 2);
    m_done = di;
    m_done[NUB] = dn;
  endtask

  task automatic check_all();
    chk("keep_out", 64'(keep_out), 64'(m_keep));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("rd_data", rd_data, m_rdata);
    chk("rd_sop", 64'(rd_sop), 64'(m_rsop));
    chk("rd_eop", 64'(rd_eop), 64'(m_reop));
    chk("done_out", 64'(done_out), 64'(m_done));
    chk("seq_err", 64'(seq_err), 64'(m_seq));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic cyc(input bit v, input logic [WS-1:0] n,
                     input logic [WP-1:0] d, input bit re,
                     input logic [PN-1:0] di);
    valid_in = v; nub_in = n; data_in = d; rd_en = re; done_in = di;
    model_step(v, n, d, re, di);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1; valid_in = 0; nub_in = '0; data_in = '0;
    rd_en = 0; done_in = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 0;
  endtask

  function automatic logic [WP-1:0] hdr(input int len);
    logic [WD-1:0] p;
    p = {$urandom, $urandom};
    p[42:35] = 8'(len);
    return {WS'(NUB), p};
  endfunction

  function automatic logic [WP-1:0] pay(input int dest);
    return {WS'(dest), $urandom, $urandom};
  endfunction

  function automatic int other_dest();
    return (NUB + 1 + int'($urandom_range(6))) % PN;
  endfunction

  task automatic push(input int n, input logic [WP-1:0] d);
    sq.push_back({WS'(n), d});
  endtask

  task automatic run(input int max_cyc, input int rd_pct);
    logic [WS+WP-1:0] w;
    bit acc, re;
    for (int c = 0; c < max_cyc && sq.size() > 0; c++) begin
      w = sq[0];
      acc = !m_keep;
      re = (int'($urandom_range(99)) < rd_pct);
      cyc(1, w[WS+WP-1:WP], w[WP-1:0], re, 8'($urandom));
      if (acc) void'(sq.pop_front());
    end
  endtask

  task automatic run_all(input int rd_pct);
    run(1000, rd_pct);
    if (sq.size() != 0) begin
      n_chk++; n_fail++;
      $error("FAIL stream_timeout observed=%0d expected=0", sq.size());
      sq.delete();
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 64 && q.size() > 0; c++)
      cyc(0, '0, '0, 1, 8'($urandom));
    cyc(0, '0, '0, 1, '0);
  endtask

  initial begin
    int len, nx;
    n_chk = 0; n_pass = 0; n_fail = 0; keep_forced = 0;
    do_reset();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_done", 64'(done_out), 64'd0);

    // len 3 frame, nubs wrap 6,7,0,1
    push(NUB, hdr(3));
    for (int i = 1; i <= 3; i++) push((NUB + i) % PN, pay(NUB));
    run_all(0);
    chk("t1_done", 64'(done_out[NUB]), 64'd1);
    drain();

    push(NUB, hdr(0));
    run_all(0);
    chk("t2_done", 64'(done_out[NUB]), 64'd1);
    drain();

    // foreign and wrong-nub words inside a frame
    push(NUB, hdr(2));
    push((NUB + 1) % PN, pay(other_dest()));
    push((NUB + 3) % PN, pay(NUB));
    run_all(0);
    chk("t3_seq", 64'(seq_err), 64'd1);
    push((NUB + 1) % PN, pay(NUB));
    push(2, pay(other_dest()));
    push((NUB + 2) % PN, pay(NUB));
    run_all(0);
    chk("t3_done", 64'(done_out[NUB]), 64'd1);
    drain();

    push(NUB, hdr(4));
    for (int i = 1; i <= 4; i++) push((NUB + i) % PN, pay(NUB));
    run_all(30);
    drain();

    // random frames with noise, bad nubs and random reads
    for (int f = 0; f < 25; f++) begin
      len = int'($urandom_range(6));
      if ($urandom_range(3) == 0) push(int'($urandom_range(7)), pay(other_dest()));
      if ($urandom_range(5) == 0) push((NUB + 1) % PN, pay(NUB));
      push(NUB, hdr(len));
      for (int i = 1; i <= len; i++) begin
        nx = (NUB + i) % PN;
        if ($urandom_range(4) == 0) push(int'($urandom_range(7)), pay(other_dest()));
        if ($urandom_range(6) == 0) push((nx + 1) % PN, pay(NUB));
        push(nx, pay(NUB));
      end
    end
    run_all(60);
    drain();

    // fill with no reads: keep must stop the stream at 14 entries
    push(NUB, hdr(30));
    for (int i = 1; i <= 30; i++) push((NUB + i) % PN, pay(NUB));
    run(20, 0);
    chk("fill_keep", 64'(keep_out), 64'd1);
    chk("fill_ovf", 64'(overflow), 64'd0);
    chk("fill_empty", 64'(empty), 64'd0);
    run_all(50);
    drain();

    // defeat keep to overrun the FIFO, then reset mid-frame
    force dut.r_keep = 1'b0;
    keep_forced = 1;
    push(NUB, hdr(40));
    for (int i = 1; i <= 20; i++) push((NUB + i) % PN, pay(NUB));
    run_all(0);
    chk("ovf_set", 64'(overflow), 64'd1);
    cyc(0, '0, '0, 1, '0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    release dut.r_keep;
    keep_forced = 0;
    do_reset();
    chk("rst2_empty", 64'(empty), 64'd1);
    chk("rst2_done", 64'(done_out), 64'd0);
    chk("rst2_ovf", 64'(overflow), 64'd0);
    push((NUB + 1) % PN, pay(NUB));
    run_all(0);
    chk("rst2_idle_seq", 64'(seq_err), 64'd1);
    push(NUB, hdr(0));
    run_all(0);
    chk("rst2_done_pulse", 64'(done_out[NUB]), 64'd1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
